// File: rtl/spi_pkg.sv
// Symbol-level definitions for the pulse-width byte link, shared by the serializer
// and the receiver so both ends agree on phase encoding.
package spi_pkg;

  localparam int   SYM_LEN   = 3;     // clock phases per symbol
  localparam logic SYM_START = 1'b1;  // level every symbol opens with
  localparam logic SYM_STOP  = 1'b0;  // level every symbol closes with

  typedef enum logic [2:0] {
    IDLE,
    PH0,
    PH1,
    PH2,
    FLUSH
  } rx_state_t;

  function automatic int frame_cycles(input int data_w);
    return SYM_LEN * data_w;
  endfunction

endpackage

// File: rtl/spi_symbol_decoder.sv
// Phase tracker for the 3-cycle pulse-width symbols: reports one decoded bit per
// good symbol, malformed symbols (sym_err) and mid-frame enable drops (sym_abort).
module spi_symbol_decoder
  import spi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic en_in,
  input  logic last_bit,
  output logic bit_valid,
  output logic bit_val,
  output logic sym_err,
  output logic sym_abort,
  output logic busy
);

  rx_state_t state, state_nxt;
  logic      bit_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bit_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == PH1) bit_q <= ~in;  // short middle phase encodes a 1
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    bit_valid = 1'b0;
    sym_err   = 1'b0;
    sym_abort = 1'b0;
    unique case (state)
      IDLE: begin
        if (en_in && (in == SYM_START)) state_nxt = PH1;
      end
      PH0: begin
        if (!en_in) begin
          sym_abort = 1'b1;
          state_nxt = IDLE;
        end else if (in != SYM_START) begin
          sym_err   = 1'b1;
          state_nxt = FLUSH;
        end else begin
          state_nxt = PH1;
        end
      end
      PH1: begin
        if (!en_in) begin
          sym_abort = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = PH2;
        end
      end
      PH2: begin
        // An enable drop is treated as an abort in every phase, so the
        // receiver is idle the cycle after the transmitter lets go.
        if (!en_in) begin
          sym_abort = 1'b1;
          state_nxt = IDLE;
        end else if (in != SYM_STOP) begin
          sym_err   = 1'b1;
          state_nxt = FLUSH;
        end else begin
          bit_valid = 1'b1;
          state_nxt = last_bit ? IDLE : PH0;
        end
      end
      FLUSH: begin
        if (!en_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bit_val = bit_q;
  assign busy    = (state != IDLE);

endmodule

// File: rtl/input_spi_rx.sv
// Receive side of the byte link: assembles decoded bits LSB first into words and
// hands them to the consumer over a valid/ready register with overrun detection.
module input_spi_rx
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              en_in,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] word_nxt;
  logic              last_bit;
  logic              bit_valid;
  logic              bit_val;
  logic              sym_err;
  logic              sym_abort;
  logic              word_done;

  spi_symbol_decoder u_dec (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .en_in     (en_in),
    .last_bit  (last_bit),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .sym_err   (sym_err),
    .sym_abort (sym_abort),
    .busy      (busy)
  );

  assign last_bit  = (cnt == CNT_W'(DATA_W - 1));
  assign word_nxt  = {bit_val, sr[DATA_W-1:1]};
  assign word_done = bit_valid && last_bit;

  // Bit counter and shift register; a bad or aborted frame discards its bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (sym_err || sym_abort) begin
      cnt <= '0;
      sr  <= '0;
    end else if (bit_valid) begin
      sr  <= word_nxt;
      cnt <= last_bit ? '0 : cnt + 1'b1;
    end
  end

  // Output register: a completed word replaces the held one only if the
  // consumer takes the old word in the same cycle; otherwise it is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= sym_err || sym_abort;
      overrun   <= 1'b0;
      if (word_done) begin
        if (!out_valid || out_ready) begin
          out       <= word_nxt;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
